// File: rtl/m_ex_mul_sequencer.sv
// rtl/m_ex_mul_sequencer.sv - iterative shift-add unsigned multiplier sequencer for the EX stage
// Optional early termination on an exhausted multiplier: MUL_EARLY_TERM_EN
module m_ex_mul_sequencer #(
  parameter int N     = 32,
  parameter int N_CNT = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ex_flush,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N_CNT-1:0] CNT_LAST = N_CNT'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [2*N-1:0]   mcand;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_sum;
  logic [N-1:0]     mplier;
  logic [N_CNT-1:0] cnt;
  logic             last_iter;
  logic             stall_req;

  // Accumulator value after this cycle's iteration; also the product on the final one.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
  assign last_iter = (cnt == CNT_LAST);
`endif

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !ex_flush) begin
          state_next = S_RUN;
          stall_req  = 1'b1;
        end
      end
      S_RUN: begin
        stall_req = 1'b1;
        if (ex_flush) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // start is ignored here: the same MUL is still sitting in EX.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Gate with reset so a held start cannot stall the pipeline while in reset.
  assign stall = stall_req && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_RUN);
      done  <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (state_next == S_RUN) begin
            mcand  <= {{N{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (state_next == S_DONE) begin
            product <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_ex_mul_sequencer.sv
// tb/tb_m_ex_mul_sequencer.sv - self-checking bench for m_ex_mul_sequencer against a product/latency model
module tb_m_ex_mul_sequencer;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           ex_flush;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           stall;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks   = 0;
  int failures = 0;
  logic [2*N-1:0] last_product = '0;

  m_ex_mul_sequencer #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ex_flush (ex_flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Cycle (relative to the start cycle) at which done is expected.
  function automatic int lat_of(input logic [N-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int top = 0;
    for (int i = 0; i < N; i++) if (b[i]) top = i + 1;
    return 1 + ((top < 1) ? 1 : top);
`else
    return N + 1;
`endif
  endfunction

  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit keep_start, input bit flush_done);
    int lat;
    logic [2*N-1:0] ea;
    logic [2*N-1:0] eb;
    logic [2*N-1:0] expv;
    lat  = lat_of(b);
    ea   = {{N{1'b0}}, a};
    eb   = {{N{1'b0}}, b};
    expv = ea * eb;
    start = 1'b1; ex_flush = 1'b0; op_a = a; op_b = b;
    #1;
    chk("accept_stall", stall, 1);
    chk("accept_done", done, 0);
    chk("accept_busy", busy, 0);
    tick;
    for (int c = 1; c < lat; c++) begin
      op_a = $urandom; op_b = $urandom;
      #1;
      chk("run_stall", stall, 1);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      tick;
    end
    ex_flush = flush_done;
    #1;
    chk("done_pulse", done, 1);
    chk("done_stall", stall, 0);
    chk("done_busy", busy, 0);
    chk("done_product", product, expv);
    last_product = expv;
    tick;
    ex_flush = 1'b0;
    if (!keep_start) begin
      start = 1'b0;
      #1;
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
      chk("after_stall", stall, 0);
      chk("after_product", product, expv);
      tick;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b1; ex_flush = 1'b0; op_a = '0; op_b = '0;
    #3;
    chk("reset_stall", stall, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    tick;
    reset = 1'b0; start = 1'b0;
    #1;
    chk("release_stall", stall, 0);
    tick;

    do_mul(32'd3, 32'd5, 1'b0, 1'b0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Flush in RUN at cycle 10.
    start = 1'b1; op_a = 32'h1234; op_b = 32'h10;
    tick;
    for (int c = 1; c < 10; c++) tick;
    ex_flush = 1'b1; start = 1'b0;
    #1;
    chk("flush_cycle_stall", stall, 1);
    tick;
    ex_flush = 1'b0;
    #1;
    chk("flush_idle_stall", stall, 0);
    chk("flush_idle_busy", busy, 0);
    chk("flush_product_kept", product, last_product);
    for (int c = 0; c < N + 4; c++) begin
      #1;
      chk("flush_no_done", done, 0);
      tick;
    end

    // Asynchronous reset at cycle 7 of a run.
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    tick;
    for (int c = 1; c < 7; c++) tick;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_product", product, 0);
    start = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);
    tick;
    last_product = '0;

    do_mul(32'd6, 32'd7, 1'b0, 1'b0);
    do_mul(32'd7, 32'd2, 1'b0, 1'b0);
    do_mul(32'd7, 32'd0, 1'b0, 1'b0);

    // Back-to-back with start held across DONE.
    do_mul(32'd2, 32'd3, 1'b1, 1'b0);
    do_mul(32'd4, 32'd5, 1'b0, 1'b0);

    // ex_flush during DONE still pulses done.
    do_mul($urandom, $urandom, 1'b0, 1'b1);

    // start together with ex_flush in IDLE is not a start.
    start = 1'b1; ex_flush = 1'b1; op_a = 32'd11; op_b = 32'd13;
    #1;
    chk("start_flush_stall", stall, 0);
    tick;
    start = 1'b0; ex_flush = 1'b0;
    #1;
    chk("start_flush_busy", busy, 0);
    tick;

    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, N - 1);
      do_mul(ra, rb, ($urandom_range(0, 1) == 1), 1'b0);
    end
    start = 1'b0;
    tick;
    #1;
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
